// File: rtl/mips_pipeline_top.sv
// mips_pipeline_top: 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset pipelined CPU.
// It has a built-in program ROM, a register file, an ALU, data memory, and
// forwarding and hazard logic. The only ports are a clock and a reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; pc=0, pipeline drained to bubbles,
//           register file and data memory cleared
// Supported instructions: add sub and or slt addi lw sw beq j jal.
// Every other encoding executes as a NOP.
// Pipeline register naming: _p1 IF/ID, _p2 ID/EX, _p3 EX/MEM, _p4 MEM/WB.

module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] rf [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && wa != 5'd0) begin
      rf[wa] <= wd;
    end
  end

  // A read of the register being written in this cycle returns the new value.
  // Because of this, ID needs no separate WB forwarding path.
  always_comb begin
    rd1 = rf[ra1];
    rd2 = rf[ra2];
    if (we && wa != 5'd0 && wa == ra1) rd1 = wd;
    if (we && wa != 5'd0 && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end
endmodule

module mips_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        vld,
  input  logic [31:0] instr,
  input  logic [3:0]  pc_hi,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wdata,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm,
  output logic [4:0]  dst,
  output logic        use_rs,
  output logic        use_rt,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        branch,
  output logic        jump,
  output logic        link,
  output logic [31:0] jump_target
);
  logic r_ok;

  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign imm         = {{16{instr[15]}}, instr[15:0]};
  assign jump_target = {pc_hi, instr[25:0], 2'b00};

  mips_regfile u_regfile (
    .clk (clk),
    .reset (reset),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_data),
    .rd2 (rt_data),
    .we (wb_we),
    .wa (wb_rd),
    .wd (wb_wdata)
  );

  // All control outputs are forced low for a bubble. A flushed slot therefore
  // cannot jump, stall or write anything.
  always_comb begin
    r_ok      = 1'b0;
    dst       = 5'd0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 3'd0;
    branch    = 1'b0;
    jump      = 1'b0;
    link      = 1'b0;
    if (vld) begin
      case (instr[31:26])
        6'h00: begin
          r_ok = 1'b1;
          case (instr[5:0])
            6'h20:   alu_op = 3'd0;
            6'h22:   alu_op = 3'd1;
            6'h24:   alu_op = 3'd2;
            6'h25:   alu_op = 3'd3;
            6'h2A:   alu_op = 3'd4;
            default: r_ok = 1'b0;
          endcase
          reg_write = r_ok;
          use_rs    = r_ok;
          use_rt    = r_ok;
          dst       = instr[15:11];
        end
        6'h08: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          use_rs    = 1'b1;
          dst       = rt;
        end
        6'h23: begin
          reg_write = 1'b1;
          mem_read  = 1'b1;
          alu_src   = 1'b1;
          use_rs    = 1'b1;
          dst       = rt;
        end
        6'h2B: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          use_rs    = 1'b1;
          use_rt    = 1'b1;
        end
        6'h04: begin
          branch = 1'b1;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        6'h02: jump = 1'b1;
        6'h03: begin
          jump      = 1'b1;
          link      = 1'b1;
          reg_write = 1'b1;
          dst       = 5'd31;
        end
        default: ;
      endcase
    end
  end
endmodule

module mips_dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] mem [0:DMEM_WORDS-1];
  logic [AW-1:0] idx;
  logic unused_addr;

  // The word index is truncated, so out-of-range addresses wrap.
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign rdata       = mem[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end
endmodule

module mips_mem_stage #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic [31:0] result
);
  logic [31:0] load_data;

  mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
    .clk (clk),
    .reset (reset),
    .we (mem_write),
    .addr (alu_result),
    .wdata (store_data),
    .rdata (load_data)
  );

  assign result = mem_read ? load_data : alu_result;
endmodule

module mips_pipeline_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic clk,
  input  logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);

  function automatic logic [31:0] rom_word(input logic [IAW-1:0] idx);
    case (int'(idx))
      0:       rom_word = 32'h2008_0003; // addi $t0,$0,3
      1:       rom_word = 32'h2009_0004; // addi $t1,$0,4
      2:       rom_word = 32'h0109_5020; // add  $t2,$t0,$t1
      3:       rom_word = 32'hAC0A_0004; // sw   $t2,4($0)
      4:       rom_word = 32'h8C0B_0004; // lw   $t3,4($0)
      5:       rom_word = 32'h0160_6020; // add  $t4,$t3,$0
      6:       rom_word = 32'h0188_8022; // sub  $s0,$t4,$t0
      7:       rom_word = 32'h1108_0001; // beq  $t0,$t0,+1
      8:       rom_word = 32'h2010_0063; // addi $s0,$0,99 (skipped)
      19:      rom_word = 32'h0C00_0016; // jal  0x58
      20:      rom_word = 32'h2011_0063; // addi $s1,$0,99 (flushed)
      22:      rom_word = 32'h2011_0001; // addi $s1,$0,1
      23:      rom_word = 32'h0800_0017; // j    0x5C
      default: rom_word = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(input logic [2:0] op,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b);
    case (op)
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = a | b;
      3'd4:    alu_fn = {31'd0, a < b};
      default: alu_fn = a + b;
    endcase
  endfunction

  logic [31:0] pc, pc_plus4, pc_next, if_instr;
  logic        unused_pc;

  logic        vld_p1;
  logic [31:0] instr_p1, pc_plus4_p1;

  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_jump_target;
  logic        id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_mem_write;
  logic        id_alu_src, id_branch, id_jump, id_link, stall;
  logic [2:0]  id_alu_op;

  logic        vld_p2, reg_write_p2, mem_read_p2, mem_write_p2;
  logic        alu_src_p2, branch_p2, link_p2;
  logic [2:0]  alu_op_p2;
  logic [4:0]  rs_p2, rt_p2, dst_p2;
  logic [31:0] rs_data_p2, rt_data_p2, imm_p2, pc_plus4_p2;

  logic signed [31:0] op_a, op_b;
  logic [31:0] alu_b, ex_result, br_target;
  logic        br_taken, fwd_mem;

  logic        vld_p3, reg_write_p3, mem_read_p3, mem_write_p3;
  logic [4:0]  dst_p3;
  logic [31:0] result_p3, store_p3, mem_result;

  logic        vld_p4, reg_write_p4;
  logic [4:0]  dst_p4;
  logic [31:0] wdata_p4;

  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;

  // ---- IF ----
  assign pc_plus4  = pc + 32'd4;
  assign if_instr  = rom_word(pc[IAW+1:2]);
  assign unused_pc = ^{pc[31:IAW+2], pc[1:0]};

  // A taken branch was fetched earlier than the jump in ID, so it wins.
  always_comb begin
    pc_next = pc_plus4;
    if (br_taken)     pc_next = br_target;
    else if (stall)   pc_next = pc;
    else if (id_jump) pc_next = id_jump_target;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  // ---- IF/ID ----
  always_ff @(posedge clk) begin
    if (reset || br_taken || id_jump) vld_p1 <= 1'b0;
    else if (!stall)                  vld_p1 <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      instr_p1    <= if_instr;
      pc_plus4_p1 <= pc_plus4;
    end
  end

  mips_id_stage u_id (
    .clk (clk),
    .reset (reset),
    .vld (vld_p1),
    .instr (instr_p1),
    .pc_hi (pc_plus4_p1[31:28]),
    .wb_we (wb_reg_write),
    .wb_rd (wb_rd),
    .wb_wdata (wb_wdata),
    .rs (id_rs),
    .rt (id_rt),
    .rs_data (id_rs_data),
    .rt_data (id_rt_data),
    .imm (id_imm),
    .dst (id_dst),
    .use_rs (id_use_rs),
    .use_rt (id_use_rt),
    .reg_write (id_reg_write),
    .mem_read (id_mem_read),
    .mem_write (id_mem_write),
    .alu_src (id_alu_src),
    .alu_op (id_alu_op),
    .branch (id_branch),
    .jump (id_jump),
    .link (id_link),
    .jump_target (id_jump_target)
  );

  // Stall only when ID actually reads the register that the load in EX will produce.
  assign stall = vld_p2 && mem_read_p2 && dst_p2 != 5'd0 &&
                 ((id_use_rs && id_rs == dst_p2) || (id_use_rt && id_rt == dst_p2));

  // ---- ID/EX ----
  always_ff @(posedge clk) begin
    if (reset || br_taken || stall) vld_p2 <= 1'b0;
    else                            vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    reg_write_p2 <= id_reg_write;
    mem_read_p2  <= id_mem_read;
    mem_write_p2 <= id_mem_write;
    alu_src_p2   <= id_alu_src;
    branch_p2    <= id_branch;
    link_p2      <= id_link;
    alu_op_p2    <= id_alu_op;
    rs_p2        <= id_rs;
    rt_p2        <= id_rt;
    dst_p2       <= id_dst;
    rs_data_p2   <= id_rs_data;
    rt_data_p2   <= id_rt_data;
    imm_p2       <= id_imm;
    pc_plus4_p2  <= pc_plus4_p1;
  end

  // ---- EX ----
  assign fwd_mem = vld_p3 && reg_write_p3 && dst_p3 != 5'd0;

  always_comb begin
    op_a = rs_data_p2;
    if (fwd_mem && dst_p3 == rs_p2)                           op_a = result_p3;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs_p2) op_a = wb_wdata;
    op_b = rt_data_p2;
    if (fwd_mem && dst_p3 == rt_p2)                           op_b = result_p3;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rt_p2) op_b = wb_wdata;
  end

  assign alu_b     = alu_src_p2 ? imm_p2 : op_b;
  assign ex_result = link_p2 ? pc_plus4_p2 : alu_fn(alu_op_p2, op_a, alu_b);
  assign br_taken  = vld_p2 && branch_p2 && (op_a == op_b);
  assign br_target = pc_plus4_p2 + (imm_p2 << 2);

  // ---- EX/MEM ----
  always_ff @(posedge clk) begin
    if (reset) vld_p3 <= 1'b0;
    else       vld_p3 <= vld_p2;
  end

  always_ff @(posedge clk) begin
    reg_write_p3 <= reg_write_p2;
    mem_read_p3  <= mem_read_p2;
    mem_write_p3 <= mem_write_p2;
    dst_p3       <= dst_p2;
    result_p3    <= ex_result;
    store_p3     <= op_b;
  end

  mips_mem_stage #(.DMEM_WORDS(DMEM_WORDS)) u_mem (
    .clk (clk),
    .reset (reset),
    .mem_read (mem_read_p3),
    .mem_write (vld_p3 && mem_write_p3),
    .alu_result (result_p3),
    .store_data (store_p3),
    .result (mem_result)
  );

  // ---- MEM/WB ----
  always_ff @(posedge clk) begin
    if (reset) vld_p4 <= 1'b0;
    else       vld_p4 <= vld_p3;
  end

  always_ff @(posedge clk) begin
    reg_write_p4 <= reg_write_p3;
    dst_p4       <= dst_p3;
    wdata_p4     <= mem_result;
  end

  assign wb_reg_write = vld_p4 && reg_write_p4;
  assign wb_rd        = dst_p4;
  assign wb_wdata     = wdata_p4;
endmodule

// File: tb/tb_mips_pipeline_top.sv
// tb_mips_pipeline_top: directed test of mips_pipeline_top. It runs the built-in
// program and checks the architectural state and the WB-stage activity
// through hierarchical names.

module tb_mips_pipeline_top;
  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  logic mon_clr = 1'b1;
  int   rd11_cnt, jal_cnt, bad99_cnt, after17_cnt;
  logic seen17;

  mips_pipeline_top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rf(input int i);
    case (i)
      8:       exp_rf = 32'd3;
      9:       exp_rf = 32'd4;
      10:      exp_rf = 32'd7;
      11:      exp_rf = 32'd7;
      12:      exp_rf = 32'd7;
      16:      exp_rf = 32'd4;
      17:      exp_rf = 32'd1;
      31:      exp_rf = 32'h0000_0050;
      default: exp_rf = 32'd0;
    endcase
  endfunction

  // WB and ID activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_clr) begin
      rd11_cnt = 0; jal_cnt = 0; bad99_cnt = 0; after17_cnt = 0; seen17 = 1'b0;
    end else begin
      if (dut.id_jump && dut.pc == 32'h0000_0050) jal_cnt++;
      if (dut.wb_reg_write) begin
        if (seen17) after17_cnt++;
        if (dut.wb_rd == 5'd11 && dut.wb_wdata == 32'd7) rd11_cnt++;
        if (dut.wb_wdata == 32'd99) bad99_cnt++;
        if (dut.wb_rd == 5'd17) seen17 = 1'b1;
      end
    end
  end

  task automatic check_final(input string ph);
    for (int i = 0; i < 32; i++)
      check_val($sformatf("%s rf[%0d]", ph, i), dut.u_id.u_regfile.rf[i], exp_rf(i));
    for (int i = 0; i < 64; i++)
      check_val($sformatf("%s mem[%0d]", ph, i), dut.u_mem.u_dmem.mem[i],
                (i == 1) ? 32'd7 : 32'd0);
    check_val({ph, " lw_wb_once"}, rd11_cnt, 32'd1);
    check_val({ph, " jal_id_jump_at_50"}, jal_cnt, 32'd1);
    check_val({ph, " no_wb_of_99"}, bad99_cnt, 32'd0);
    check_val({ph, " rd17_written"}, {31'd0, seen17}, 32'd1);
    check_val({ph, " no_wb_after_rd17"}, after17_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] acc;
    logic [31:0] prev_pc;

    // Power-up reset held for two cycles.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset pc", dut.pc, 32'd0);
    check_val("reset wb_reg_write", {31'd0, dut.wb_reg_write}, 32'd0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.u_id.u_regfile.rf[i];
    check_val("reset rf_or", acc, 32'd0);
    acc = '0;
    for (int i = 0; i < 64; i++) acc |= dut.u_mem.u_dmem.mem[i];
    check_val("reset mem_or", acc, 32'd0);

    reset   = 1'b0;
    mon_clr = 1'b0;
    repeat (48) @(negedge clk);
    check_final("run1");

    // Halt loop: pc alternates between the j and its flushed successor.
    prev_pc = dut.pc;
    check_val("halt pc_in_loop",
              {31'd0, (prev_pc == 32'h5C) || (prev_pc == 32'h60)}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("halt pc_alt[%0d]", k), dut.pc,
                (prev_pc == 32'h5C) ? 32'h60 : 32'h5C);
      prev_pc = dut.pc;
    end
    check_val("halt no_wb_after_rd17", after17_cnt, 32'd0);

    // Fresh start, then reset again for one cycle mid-program.
    mon_clr = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    mon_clr = 1'b0;
    repeat (10) @(negedge clk);
    check_val("mid pre_reset rf[8]", dut.u_id.u_regfile.rf[8], 32'd3);
    mon_clr = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    check_val("mid reset pc", dut.pc, 32'd0);
    check_val("mid reset wb_reg_write", {31'd0, dut.wb_reg_write}, 32'd0);
    check_val("mid reset rf[8]", dut.u_id.u_regfile.rf[8], 32'd0);
    check_val("mid reset rf[10]", dut.u_id.u_regfile.rf[10], 32'd0);
    check_val("mid reset mem[1]", dut.u_mem.u_dmem.mem[1], 32'd0);
    reset   = 1'b0;
    mon_clr = 1'b0;
    repeat (48) @(negedge clk);
    check_final("run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
